light_switch_ctrl: RTL and testbench
====================================

Name: light_switch_ctrl

Overview:
- Front end of the light path. Turns the raw, bouncing light push-button into a clean toggled light request.
- Path: 2-flop synchronizer -> press/release debounce FSM -> toggle register.
- light_req drives the `light` input of the light driver block. Gated by power_on exactly as the driver expects.

Parameters:
DEBOUNCE_CYCLES, 2000000, stable-level cycles needed to accept a press or release (20 ms at 100 MHz); legal range >= 2
AUTO_OFF_CYCLES, 500000000, cycles of continuous light-on before forced off (5 s at 100 MHz); used only with LIGHT_AUTO_OFF_EN

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-low; when 0 at a rising clk edge all state clears
power_on  input  1  appliance power state; 0 forces light off and blocks toggling
btn_raw  input  1  asynchronous, bouncing light button, 1 = pressed
light_req  output  1  registered light request to the light driver
press_pulse  output  1  one-cycle strobe per accepted press while powered
btn_stable  output  1  debounced button level (1 in HELD/RELEASE_WAIT)
auto_off_evt  output  1  one-cycle strobe when the auto-off timer turns the light off

Behaviour:
- Reset (reset==0 at edge): sync flops=0, state=IDLE, cnt=0, light_req=0, press_pulse=0, auto_off_evt=0, auto-off timer=0. Reset has priority over every other event, including mid-debounce.
- Synchronizer: btn_raw -> s1 -> btn_s, 2 flops. Only btn_s is used downstream.
- Counter cnt has width $clog2(DEBOUNCE_CYCLES). It saturates at the compare value and never wraps.
- FSM states and transitions:
  - IDLE: btn_s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected). Else, if cnt==DEBOUNCE_CYCLES-1 -> HELD (accept). Else cnt<=cnt+1.
  - HELD: btn_s=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: btn_s=1 -> HELD (release bounce, no new press). Else, if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt<=cnt+1.
- Accept edge (PRESS_WAIT->HELD):
  - If power_on=1: press_pulse<=1 and light_req<=~light_req.
  - If power_on=0: state still advances, no pulse, no toggle.
- press_pulse is 0 on every other cycle.
- Latency: btn_raw first sampled high at edge j, held clean -> light_req toggles at edge j+2+DEBOUNCE_CYCLES.
- One toggle per physical press. Holding the button indefinitely produces no repeats.
- power_on=0: light_req<=0 every cycle (overrides a toggle in the same cycle). FSM keeps tracking the button.
- power_on 0->1: light_req stays 0 until the next accepted press. No stored state is restored.
- btn_stable = (state==HELD || state==RELEASE_WAIT). Combinational from the state register.

Optional Feature:
Macro LIGHT_AUTO_OFF_EN.
- Defined:
  - Timer tmr, width $clog2(AUTO_OFF_CYCLES). Increments each cycle while light_req=1 and power_on=1.
  - tmr clears to 0 whenever light_req=0, power_on=0, or an accepted press occurs.
  - When tmr==AUTO_OFF_CYCLES-1: light_req<=0, auto_off_evt<=1 for one cycle, tmr<=0.
  - Accepted press and timeout on the same edge: the press wins. light_req<=~light_req (=0), auto_off_evt stays 0.
  - power_on=0 on the timeout edge: light_req<=0, auto_off_evt stays 0.
- Not defined: no timer logic; auto_off_evt tied to 0; AUTO_OFF_CYCLES ignored.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=4, power_on=1), btn_raw high from edge 0 for 20 cycles -> light_req 0->1 at edge 6, press_pulse=1 only at that edge, btn_stable=1 from edge 6; release -> no further change.
- Bounce reject, btn_raw 1,1,0,1,0 (each 2 cycles) then 0 -> light_req stays 0, press_pulse never asserts, state returns to IDLE.
- Release bounce, press accepted then btn_raw 0 for 2 cycles, 1 for 2, held 10 -> exactly one toggle, no second press_pulse.
- Power gating, light_req=1 then power_on=0 -> light_req=0 next edge; press during power-off -> no pulse, light_req 0; power_on=1 -> light_req remains 0 until next press.
- Reset mid-debounce, reset=0 for 1 edge during PRESS_WAIT cnt=2 -> all outputs 0, state IDLE; held btn then needs a full DEBOUNCE_CYCLES again.
- With LIGHT_AUTO_OFF_EN (AUTO_OFF_CYCLES=20), press to turn on and wait -> light_req=0 and auto_off_evt=1 exactly 20 cycles after the on-edge. A press at cycle 19 -> light_req=0 via toggle, auto_off_evt=0.

Source files
------------

// File: rtl/light_switch_ctrl.sv
// Light push-button front end: 2-flop synchronizer, press/release debounce FSM and toggle register.
// Optional auto-off timer is built in when LIGHT_AUTO_OFF_EN is defined.
module light_switch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned AUTO_OFF_CYCLES = 500000000
) (
  input  logic clk,
  input  logic reset,
  input  logic power_on,
  input  logic btn_raw,
  output logic light_req,
  output logic press_pulse,
  output logic btn_stable,
  output logic auto_off_evt
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, btn_s_q;
  logic             light_q, light_d;
  logic             pulse_q, pulse_d;
  logic             accept;
  logic             timeout_hit;

  // Synchronizer stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw;
      btn_s_q <= s1_q;
    end
  end

  // Debounce FSM stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A rebound during release returns to HELD without counting as a new press
        if (btn_s_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LIGHT_AUTO_OFF_EN
  localparam int unsigned     TMR_W   = $clog2(AUTO_OFF_CYCLES);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(AUTO_OFF_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             evt_q;

  // Press and power-off both take precedence over the timeout
  assign timeout_hit = light_q && power_on && !accept && (tmr_q == TMR_MAX);

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if (!light_q || !power_on || accept || timeout_hit) begin
      tmr_d = '0;
    end
  end

  // Auto-off timer stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q <= '0;
      evt_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      evt_q <= timeout_hit;
    end
  end

  assign auto_off_evt = evt_q;
`else
  assign timeout_hit  = 1'b0;
  assign auto_off_evt = 1'b0;
`endif

  always_comb begin
    light_d = light_q;
    pulse_d = accept && power_on;
    if (!power_on) begin
      light_d = 1'b0;
    end else if (accept) begin
      light_d = ~light_q;
    end else if (timeout_hit) begin
      light_d = 1'b0;
    end
  end

  // Toggle register stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      light_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      light_q <= light_d;
      pulse_q <= pulse_d;
    end
  end

  assign light_req   = light_q;
  assign press_pulse = pulse_q;
  assign btn_stable  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_light_switch_ctrl.sv
// Bench for light_switch_ctrl with DEBOUNCE_CYCLES=4 and AUTO_OFF_CYCLES=20.
// Vector table of {inputs, repeat count, expected outputs}; expectations flow through a scoreboard queue.
module tb_light_switch_ctrl;

  logic clk = 1'b0;
  logic reset, power_on, btn_raw;
  logic light_req, press_pulse, btn_stable, auto_off_evt;

  light_switch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_OFF_CYCLES(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .power_on    (power_on),
    .btn_raw     (btn_raw),
    .light_req   (light_req),
    .press_pulse (press_pulse),
    .btn_stable  (btn_stable),
    .auto_off_evt(auto_off_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic pwr;
    logic btn;
    int   reps;
    logic l;
    logic p;
    logic s;
    logic e;
  } vec_t;

  typedef struct {
    int   row;
    logic l;
    logic p;
    logic s;
    logic e;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic void add(logic r, logic pw, logic b, int n,
                              logic l, logic p, logic s, logic e);
    vec_t v;
    v.rst_n = r; v.pwr = pw; v.btn = b; v.reps = n;
    v.l = l; v.p = p; v.s = s; v.e = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b expected %b at t=%0t", name, row, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "bench did not complete");
  end

  initial begin
    exp_t e;
    int   n;
    logic hand_light_exp;

`ifdef LIGHT_AUTO_OFF_EN
    add(0,0,0, 2, 0,0,0,0);
    // turn on and hold: timeout 20 edges after the on-edge
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1,19, 1,0,1,0);
    add(1,1,1, 1, 0,0,1,1);
    add(1,1,1, 3, 0,0,1,0);
    add(1,1,0, 6, 0,0,1,0);
    add(1,1,0, 3, 0,0,0,0);
    // turn on, release, re-press so the accept lands on the timeout edge
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,0, 6, 1,0,1,0);
    add(1,1,0, 7, 1,0,0,0);
    add(1,1,1, 6, 1,0,0,0);
    add(1,1,1, 1, 0,1,1,0);
    add(1,1,1,25, 0,0,1,0);
    add(1,1,0, 6, 0,0,1,0);
    add(1,1,0, 3, 0,0,0,0);
    // power drops on the timeout edge: no event
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1,19, 1,0,1,0);
    add(1,0,1, 1, 0,0,1,0);
    add(1,1,1, 3, 0,0,1,0);
    add(1,1,0, 6, 0,0,1,0);
    add(1,1,0, 3, 0,0,0,0);
    hand_light_exp = 1'b1;
`else
    add(0,0,0, 2, 0,0,0,0);
    // clean press, then release
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1,13, 1,0,1,0);
    add(1,1,0, 6, 1,0,1,0);
    add(1,1,0, 4, 1,0,0,0);
    // bounce rejected one cycle short of acceptance
    add(1,1,1, 4, 1,0,0,0);
    add(1,1,0, 2, 1,0,0,0);
    add(1,1,1, 2, 1,0,0,0);
    add(1,1,0, 6, 1,0,0,0);
    // release bounce: one toggle only
    add(1,1,1, 6, 1,0,0,0);
    add(1,1,1, 1, 0,1,1,0);
    add(1,1,1, 3, 0,0,1,0);
    add(1,1,0, 2, 0,0,1,0);
    add(1,1,1,12, 0,0,1,0);
    add(1,1,0, 6, 0,0,1,0);
    add(1,1,0, 3, 0,0,0,0);
    // power gating
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1, 2, 1,0,1,0);
    add(1,1,0, 6, 1,0,1,0);
    add(1,1,0, 3, 1,0,0,0);
    add(1,0,0, 1, 0,0,0,0);
    add(1,0,1, 6, 0,0,0,0);
    add(1,0,1, 1, 0,0,1,0);
    add(1,0,1, 2, 0,0,1,0);
    add(1,0,0, 6, 0,0,1,0);
    add(1,0,0, 3, 0,0,0,0);
    add(1,1,0, 5, 0,0,0,0);
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1, 2, 1,0,1,0);
    add(1,0,1, 1, 0,0,1,0);
    add(1,1,1, 4, 0,0,1,0);
    add(1,1,0, 6, 0,0,1,0);
    add(1,1,0, 3, 0,0,0,0);
    // light on, then reset mid-debounce
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1, 2, 1,0,1,0);
    add(1,1,0, 6, 1,0,1,0);
    add(1,1,0, 3, 1,0,0,0);
    add(1,1,1, 5, 1,0,0,0);
    add(0,1,1, 1, 0,0,0,0);
    add(1,1,1, 6, 0,0,0,0);
    add(1,1,1, 1, 1,1,1,0);
    add(1,1,1, 2, 1,0,1,0);
    add(1,1,0, 6, 1,0,1,0);
    add(1,1,0, 3, 1,0,0,0);
    hand_light_exp = 1'b0;
`endif

    reset = 1'b0; power_on = 1'b0; btn_raw = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      for (int k = 0; k < vecs[r].reps; k++) begin
        @(negedge clk);
        reset    = vecs[r].rst_n;
        power_on = vecs[r].pwr;
        btn_raw  = vecs[r].btn;
        e.row = r; e.l = vecs[r].l; e.p = vecs[r].p; e.s = vecs[r].s; e.e = vecs[r].e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("light_req",    e.row, light_req,    e.l);
        chk("press_pulse",  e.row, press_pulse,  e.p);
        chk("btn_stable",   e.row, btn_stable,   e.s);
        chk("auto_off_evt", e.row, auto_off_evt, e.e);
      end
    end

    // Hand sequence: latency from first high sample to press_pulse, bounded
    @(negedge clk);
    reset = 1'b1; power_on = 1'b1; btn_raw = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse === 1'b1) break;
      n++;
    end
    chk_int("press_latency", n, 6);
    chk("hand_light", -1, light_req, hand_light_exp);
    chk("hand_stable", -1, btn_stable, 1'b1);
    @(posedge clk);
    #1;
    chk("hand_pulse_drop", -1, press_pulse, 1'b0);
    chk("hand_light_hold", -1, light_req, hand_light_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
